// File: rtl/ahb_sram_slave.sv
// AHB-lite responder backed by a word-addressed register-file memory.
// Adds WAIT_STATES wait cycles to every OKAY transfer and returns a two-cycle ERROR for illegal accesses.
module ahb_sram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic                  hready,
  input  logic [31:0]           hwdata,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [31:0]           hrdata
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_ERR1 = 2'd2;
  localparam logic [1:0] ST_ERR2 = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       lane_q, lane_d;
  logic [2:0]       size_q, size_d;
  logic             write_q, write_d;
  logic [31:0]      mem_q [MEM_DEPTH];

  logic       accept;
  logic       illegal;
  logic       out_of_range;
  logic       complete;
  logic       can_start;
  logic [3:0] byte_en;
  logic       unused_inputs;

  // Bus qualifiers and attributes this slave does not act on.
  assign unused_inputs = ^{hburst, hprot, htrans[0]};

  assign accept       = hsel && hready && htrans[1];
  assign out_of_range = {2'b00, haddr[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(MEM_DEPTH);
  assign complete     = (state_q == ST_XFER) && (cnt_q == 4'd0);
  assign can_start    = (state_q == ST_IDLE) || (state_q == ST_ERR2) || complete;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    illegal = out_of_range;
    case (hsize)
      3'd0:    illegal = out_of_range;
      3'd1:    illegal = out_of_range || haddr[0];
      3'd2:    illegal = out_of_range || (haddr[1:0] != 2'b00);
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    size_d  = size_q;
    write_d = write_q;

    case (state_q)
      ST_XFER: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase

    // A new address phase may overlap the completion cycle of the previous transfer.
    if (can_start && accept) begin
      idx_d   = haddr[IDX_W+1:2];
      lane_d  = haddr[1:0];
      size_d  = hsize;
      write_d = hwrite;
      if (illegal) begin
        state_d = ST_ERR1;
        cnt_d   = 4'd0;
      end else begin
        state_d = ST_XFER;
        cnt_d   = 4'(WAIT_STATES);
      end
    end
  end

  // Little-endian lane enables for the registered access.
  always_comb begin
    byte_en = 4'b0000;
    case (size_q)
      3'd0:    byte_en = 4'b0001 << lane_q;
      3'd1:    byte_en = lane_q[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  always_ff @(posedge hclk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (hreset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      lane_q  <= 2'b00;
      size_q  <= 3'd0;
      write_q <= 1'b0;
      // NOTE: the memory is a register file that must read back as zero after reset, so it is cleared word by word.
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      write_q <= write_d;
      if (complete && write_q) begin
        for (int b = 0; b < 4; b++) begin
          if (byte_en[b]) begin
            mem_q[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
          end
        end
      end
    end
  end

  assign hreadyout = (state_q == ST_IDLE) || (state_q == ST_ERR2) || complete;
  assign hresp     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
  assign hrdata    = (complete && !write_q) ? mem_q[idx_q] : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: three instances (0, 2 and 3 wait states) driven by a pipelined master,
// checked every cycle against a queue-of-expected-responses model with a byte-addressed memory.
module tb_ahb_sram_slave;

  typedef struct {
    logic [1:0]  trans;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    bit          stall;
  } txn_t;

  typedef struct {
    bit   rdy;
    bit   resp;
    int   kind;   // 0: no data, 1: read completes, 2: write completes
    txn_t t;
  } exp_t;

  logic        hclk = 1'b0;
  logic        hreset_a    [3];
  logic        hsel_a      [3];
  logic [31:0] haddr_a     [3];
  logic [1:0]  htrans_a    [3];
  logic        hwrite_a    [3];
  logic [2:0]  hsize_a     [3];
  logic        hready_a    [3];
  logic        stall_a     [3];
  logic [31:0] hwdata_a    [3];
  logic        hreadyout_a [3];
  logic        hresp_a     [3];
  logic [31:0] hrdata_a    [3];

  logic [7:0]  mmem [3][1024];
  txn_t        pend[$];
  exp_t        expq[$];
  logic [31:0] rd_log[$];
  logic [1:0]  ro_log[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 hclk = ~hclk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign hready_a[g] = hreadyout_a[g] & ~stall_a[g];
    ahb_sram_slave #(
      .ADDR_WIDTH (32),
      .MEM_DEPTH  (256),
      .WAIT_STATES((g == 0) ? 0 : (g == 1) ? 2 : 3)
    ) u_dut (
      .hclk     (hclk),
      .hreset   (hreset_a[g]),
      .hsel     (hsel_a[g]),
      .haddr    (haddr_a[g]),
      .htrans   (htrans_a[g]),
      .hwrite   (hwrite_a[g]),
      .hsize    (hsize_a[g]),
      .hburst   (3'b001),
      .hprot    (4'b0011),
      .hready   (hready_a[g]),
      .hwdata   (hwdata_a[g]),
      .hreadyout(hreadyout_a[g]),
      .hresp    (hresp_a[g]),
      .hrdata   (hrdata_a[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int ws_of(input int inst);
    return (inst == 0) ? 0 : (inst == 1) ? 2 : 3;
  endfunction

  function automatic bit is_illegal(input txn_t t);
    return (t.size > 3'd2) || (t.size == 3'd1 && t.addr[0]) ||
           (t.size == 3'd2 && t.addr[1:0] != 2'b00) || ((t.addr >> 2) >= 32'd256);
  endfunction

  function automatic logic [31:0] model_read(input int inst, input logic [31:0] addr);
    int b;
    b = int'(addr & 32'h3FC);
    return {mmem[inst][b+3], mmem[inst][b+2], mmem[inst][b+1], mmem[inst][b]};
  endfunction

  task automatic model_write(input int inst, input txn_t t);
    int a;
    a = int'(t.addr[9:0]);
    for (int k = 0; k < (1 << t.size); k++) begin
      mmem[inst][a+k] = t.wdata[8*((a+k)%4) +: 8];
    end
  endtask

  task automatic model_clear(input int inst);
    for (int i = 0; i < 1024; i++) mmem[inst][i] = 8'h00;
  endtask

  function automatic txn_t mk(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                              input logic [31:0] wdata);
    txn_t t;
    t.trans = 2'b10;
    t.wr    = wr;
    t.addr  = addr;
    t.size  = size;
    t.wdata = wdata;
    t.stall = 1'b0;
    return t;
  endfunction

  // Pipelined master plus per-cycle comparison; called and returns at posedge+#1.
  task automatic run(input int inst, input int reset_cycle);
    txn_t ap, dp;
    exp_t e, idle_e;
    bit   ap_v, dp_v, rdy, stall_now;
    int   cyc, idle;
    ap_v = 0; dp_v = 0; cyc = 0; idle = 0;
    idle_e.rdy = 1; idle_e.resp = 0; idle_e.kind = 0;
    forever begin
      if (!ap_v && pend.size() > 0) begin
        ap   = pend.pop_front();
        ap_v = 1;
      end
      stall_now         = ap_v && ap.stall;
      stall_a[inst]     = stall_now;
      hsel_a[inst]      = ap_v;
      htrans_a[inst]    = ap_v ? ap.trans : 2'b00;
      haddr_a[inst]     = ap_v ? ap.addr : 32'h0;
      hwrite_a[inst]    = ap_v && ap.wr;
      hsize_a[inst]     = ap_v ? ap.size : 3'd0;
      rdy               = hreadyout_a[inst] && !stall_now;
      hwdata_a[inst]    = (dp_v && rdy) ? dp.wdata : $urandom();
      hreset_a[inst]    = (cyc == reset_cycle);

      @(negedge hclk);
      e = (expq.size() > 0) ? expq[0] : idle_e;
      check($sformatf("i%0d c%0d hreadyout", inst, cyc), 32'(hreadyout_a[inst]), 32'(e.rdy));
      check($sformatf("i%0d c%0d hresp", inst, cyc), 32'(hresp_a[inst]), 32'(e.resp));
      if (e.kind != 2)
        check($sformatf("i%0d c%0d hrdata", inst, cyc), hrdata_a[inst],
              (e.kind == 1) ? model_read(inst, e.t.addr) : 32'h0);
      if (e.kind == 1) rd_log.push_back(hrdata_a[inst]);
      ro_log.push_back({hreadyout_a[inst], hresp_a[inst]});

      @(posedge hclk);
      #1;
      if (cyc == reset_cycle) begin
        expq.delete();
        pend.delete();
        model_clear(inst);
        ap_v = 0;
        dp_v = 0;
        hreset_a[inst] = 1'b0;
      end else begin
        if (expq.size() > 0) begin
          e = expq.pop_front();
          if (e.kind == 2) model_write(inst, e.t);
        end
        if (rdy) begin
          dp_v = ap_v && ap.trans[1];
          dp   = ap;
          if (dp_v) begin
            if (is_illegal(ap)) begin
              expq.push_back('{rdy: 0, resp: 1, kind: 0, t: ap});
              expq.push_back('{rdy: 1, resp: 1, kind: 0, t: ap});
            end else begin
              for (int k = 0; k < ws_of(inst); k++) expq.push_back('{rdy: 0, resp: 0, kind: 0, t: ap});
              expq.push_back('{rdy: 1, resp: 0, kind: ap.wr ? 2 : 1, t: ap});
            end
          end
          ap_v = 0;
        end else if (ap_v) begin
          ap.stall = 1'b0;
        end
      end
      stall_a[inst] = 1'b0;
      cyc++;
      if (pend.size() == 0 && !ap_v && expq.size() == 0) idle++;
      if (idle >= 2) return;
      if (cyc > 400) begin
        check($sformatf("i%0d run timeout", inst), 32'(cyc), 32'd400);
        return;
      end
    end
  endtask

  task automatic clear_logs();
    rd_log.delete();
    ro_log.delete();
  endtask

  initial begin
    txn_t t;
    for (int i = 0; i < 3; i++) begin
      hreset_a[i] = 1'b1; hsel_a[i] = 1'b0; haddr_a[i] = '0; htrans_a[i] = 2'b00;
      hwrite_a[i] = 1'b0; hsize_a[i] = 3'd0; hwdata_a[i] = '0; stall_a[i] = 1'b0;
      model_clear(i);
    end
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset i%0d hreadyout", i), 32'(hreadyout_a[i]), 32'd1);
      check($sformatf("reset i%0d hresp", i), 32'(hresp_a[i]), 32'd0);
      check($sformatf("reset i%0d hrdata", i), hrdata_a[i], 32'h0);
    end
    @(posedge hclk);
    #1;
    for (int i = 0; i < 3; i++) hreset_a[i] = 1'b0;

    // Zero-wait write then read-back of the same word.
    clear_logs();
    pend.push_back(mk(1, 32'h10, 3'd2, 32'hDEADBEEF));
    pend.push_back(mk(0, 32'h10, 3'd2, 32'h0));
    run(0, -1);
    check("rw0 read data", rd_log[0], 32'hDEADBEEF);
    begin
      int lows = 0;
      foreach (ro_log[i]) if (ro_log[i][1] == 1'b0) lows++;
      check("rw0 hreadyout never low", 32'(lows), 32'd0);
    end

    // Byte lanes, then a half-word over the upper lanes; BUSY/IDLE with hsel start nothing.
    clear_logs();
    pend.push_back(mk(1, 32'h20, 3'd0, 32'h11111111));
    pend.push_back(mk(1, 32'h21, 3'd0, 32'h22222222));
    t = mk(1, 32'h01, 3'd3, 32'hFFFFFFFF); t.trans = 2'b01; pend.push_back(t);
    pend.push_back(mk(1, 32'h22, 3'd0, 32'h33333333));
    pend.push_back(mk(1, 32'h23, 3'd0, 32'h44444444));
    t = mk(1, 32'h20, 3'd2, 32'hFFFFFFFF); t.trans = 2'b00; pend.push_back(t);
    pend.push_back(mk(0, 32'h20, 3'd2, 32'h0));
    pend.push_back(mk(1, 32'h22, 3'd1, 32'hABCDABCD));
    pend.push_back(mk(0, 32'h20, 3'd2, 32'h0));
    run(0, -1);
    check("bytes word read", rd_log[0], 32'h44332211);
    check("half overwrite read", rd_log[1], 32'hABCD2211);

    // Two wait states; the write's address phase meets a stalled bus first.
    t = mk(1, 32'h0C, 3'd2, 32'h12345678); t.stall = 1'b1; pend.push_back(t);
    run(1, -1);
    clear_logs();
    pend.push_back(mk(0, 32'h0C, 3'd2, 32'h0));
    run(1, -1);
    check("ws2 ready c1", 32'(ro_log[1][1]), 32'd0);
    check("ws2 ready c2", 32'(ro_log[2][1]), 32'd0);
    check("ws2 ready c3", 32'(ro_log[3][1]), 32'd1);
    check("ws2 read data", rd_log[0], 32'h12345678);

    // Out-of-range read and write; the write must not alias onto word 0.
    clear_logs();
    pend.push_back(mk(0, 32'h400, 3'd2, 32'h0));
    run(1, -1);
    check("oob err cycle1", 32'(ro_log[1]), 32'b01);
    check("oob err cycle2", 32'(ro_log[2]), 32'b11);
    clear_logs();
    pend.push_back(mk(1, 32'h400, 3'd2, 32'hFFFFFFFF));
    pend.push_back(mk(0, 32'h000, 3'd2, 32'h0));
    run(1, -1);
    check("oob write no alias", rd_log[0], 32'h0);

    // Misaligned and oversized accesses back to back.
    clear_logs();
    pend.push_back(mk(1, 32'h02, 3'd2, 32'hFFFFFFFF));
    pend.push_back(mk(1, 32'h00, 3'd3, 32'hFFFFFFFF));
    pend.push_back(mk(1, 32'h01, 3'd1, 32'hFFFFFFFF));
    pend.push_back(mk(0, 32'h00, 3'd2, 32'h0));
    run(0, -1);
    check("misaligned err c1", 32'(ro_log[1]), 32'b01);
    check("misaligned err c2", 32'(ro_log[2]), 32'b11);
    check("after errors read", rd_log[0], 32'h0);

    // Reset in the second wait cycle of a three-wait write.
    pend.push_back(mk(1, 32'h0C, 3'd2, 32'hCAFEF00D));
    run(2, -1);
    clear_logs();
    pend.push_back(mk(1, 32'h08, 3'd2, 32'h5A5A5A5A));
    run(2, 2);
    check("post-reset ready/resp", 32'(ro_log[3]), 32'b10);
    clear_logs();
    pend.push_back(mk(0, 32'h08, 3'd2, 32'h0));
    pend.push_back(mk(0, 32'h0C, 3'd2, 32'h0));
    run(2, -1);
    check("reset abandons write", rd_log[0], 32'h0);
    check("reset clears memory", rd_log[1], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
